// File: rtl/iguana_eoc_pkg.sv
// rtl/iguana_eoc_pkg.sv - shared types, defaults and strobe-merge helper for the EOC monitor
// Purpose: monitor state encoding, default parameter values and the byte-strobe
//          merge used to update the shadow copy of the EOC scratch register.
// Ports:   none (package).
package iguana_eoc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DONE    = 2'd1,
        TIMEOUT = 2'd2
    } eoc_state_e;

    localparam logic [31:0] DEFAULT_EOC_ADDR      = 32'h0300_0008;
    localparam int          DEFAULT_TICK_CYCLES   = 50000;
    localparam int          DEFAULT_TIMEOUT_TICKS = 100;

    // Bytes with their strobe set take the write data, the rest keep the old value.
    function automatic logic [31:0] merge_strb(input logic [31:0] old_value,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
        logic [31:0] result;
        result = old_value;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                result[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/iguana_tick_gen.sv
// rtl/iguana_tick_gen.sv - prescaler producing one wrap per TickCycles enabled cycles
// Purpose: counts 0..TickCycles-1 while enabled and holds otherwise.
// Ports:   clk, rst (async, active-high), clear (sync), enable;
//          wrap (combinational, last count while enabled), tick (wrap registered).
module iguana_tick_gen
    import iguana_eoc_pkg::*;
#(
    parameter int TickCycles = DEFAULT_TICK_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic wrap,
    output logic tick
);

    localparam int              CountWidth = $clog2(TickCycles);
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(TickCycles - 1);

    logic [CountWidth-1:0] count;

    assign wrap = enable && (count == LastCount);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= wrap;
            if (enable) begin
                count <= wrap ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iguana_eoc_monitor.sv
// rtl/iguana_eoc_monitor.sv - passive bus snooper capturing the EOC exit code with progress ticks and timeout
// Purpose: shadows writes to the EOC scratch register, latches the exit code when
//          bit0 is written as 1, counts progress ticks and flags a timeout.
// Ports:   clk_i, rst_i (async, active-high), clear_i (sync);
//          req_valid_i/req_ready_i/req_write_i/req_addr_i/req_wdata_i/req_wstrb_i (snooped bus);
//          tick_o, elapsed_o, eoc_o, exit_code_o, pass_o, timeout_o.
module iguana_eoc_monitor
    import iguana_eoc_pkg::*;
#(
    parameter int                   AddrWidth    = 32,
    parameter logic [AddrWidth-1:0] EocAddr      = AddrWidth'(DEFAULT_EOC_ADDR),
    parameter int                   TickCycles   = DEFAULT_TICK_CYCLES,
    parameter int                   TimeoutTicks = DEFAULT_TIMEOUT_TICKS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 req_valid_i,
    input  logic                 req_ready_i,
    input  logic                 req_write_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [3:0]           req_wstrb_i,
    output logic                 tick_o,
    output logic [31:0]          elapsed_o,
    output logic                 eoc_o,
    output logic [30:0]          exit_code_o,
    output logic                 pass_o,
    output logic                 timeout_o
);

    eoc_state_e  state_q, state_d;
    logic [31:0] shadow;
    logic [31:0] merged;
    logic [31:0] elapsed;
    logic [31:0] elapsed_inc;
    logic [30:0] exit_code;
    logic        hit;
    logic        eoc_hit;
    logic        timeout_hit;
    logic        running;
    logic        wrap;
    logic        unused_addr_lsb;

    assign running = (state_q == RUN);

    // Byte offset within the word is irrelevant to the hit decode.
    assign unused_addr_lsb = ^req_addr_i[1:0];
    assign hit = req_valid_i && req_ready_i && req_write_i &&
                 (req_addr_i[AddrWidth-1:2] == EocAddr[AddrWidth-1:2]);

    assign merged  = merge_strb(shadow, req_wdata_i, req_wstrb_i);
    // EOC needs bit0 actually written in this transfer, not merely held in the shadow.
    assign eoc_hit = running && hit && req_wstrb_i[0] && merged[0];

    assign elapsed_inc = (elapsed == 32'hFFFF_FFFF) ? elapsed : elapsed + 32'd1;
    assign timeout_hit = (TimeoutTicks != 0) && wrap &&
                         (elapsed_inc >= 32'(TimeoutTicks));

    iguana_tick_gen #(
        .TickCycles(TickCycles)
    ) u_tick_gen (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (clear_i),
        .enable(running),
        .wrap  (wrap),
        .tick  (tick_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // EOC is checked before timeout so a coincident EOC wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (eoc_hit) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = TIMEOUT;
                end
            end
            default: state_d = state_q;
        endcase
        if (clear_i) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow    <= '0;
            elapsed   <= '0;
            exit_code <= '0;
        end else if (clear_i) begin
            shadow    <= '0;
            elapsed   <= '0;
            exit_code <= '0;
        end else if (running) begin
            if (hit) begin
                shadow <= merged;
            end
            if (wrap) begin
                elapsed <= elapsed_inc;
            end
            if (eoc_hit) begin
                exit_code <= merged[31:1];
            end
        end
    end

    assign elapsed_o   = elapsed;
    assign exit_code_o = exit_code;
    assign eoc_o       = (state_q == DONE);
    assign timeout_o   = (state_q == TIMEOUT);
    assign pass_o      = eoc_o && (exit_code == 31'd0);

endmodule

// File: tb/tb_iguana_eoc_monitor.sv
// tb/tb_iguana_eoc_monitor.sv - self-checking bench for iguana_eoc_monitor
module tb_iguana_eoc_monitor;

    localparam int          T_CYC  = 4;
    localparam int          T_OUT  = 3;
    localparam logic [31:0] EOC_A  = 32'h0300_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        tick;
    logic [31:0] elapsed;
    logic        eoc;
    logic [30:0] exit_code;
    logic        pass;
    logic        timeout;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: 0 = running, 1 = done, 2 = timed out.
    int          m_state;
    int          m_cycles;
    logic [31:0] m_shadow;
    logic [31:0] m_elapsed;
    logic [30:0] m_exit;
    logic        m_tick;

    always #5 clk = ~clk;

    iguana_eoc_monitor #(
        .AddrWidth   (32),
        .EocAddr     (EOC_A),
        .TickCycles  (T_CYC),
        .TimeoutTicks(T_OUT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (clear),
        .req_valid_i(req_valid),
        .req_ready_i(req_ready),
        .req_write_i(req_write),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb),
        .tick_o     (tick),
        .elapsed_o  (elapsed),
        .eoc_o      (eoc),
        .exit_code_o(exit_code),
        .pass_o     (pass),
        .timeout_o  (timeout)
    );

    task automatic model_reset();
        m_state   = 0;
        m_cycles  = 0;
        m_shadow  = '0;
        m_elapsed = '0;
        m_exit    = '0;
        m_tick    = 1'b0;
    endtask

    // Advances the model by the cycle whose inputs are currently driven.
    task automatic model_step();
        logic        is_hit;
        logic        is_wrap;
        logic [31:0] upd;
        if (clear) begin
            model_reset();
        end else if (m_state == 0) begin
            is_hit  = req_valid && req_ready && req_write && ((req_addr >> 2) == (EOC_A >> 2));
            is_wrap = (m_cycles % T_CYC) == (T_CYC - 1);
            m_cycles++;
            upd = m_shadow;
            for (int b = 0; b < 4; b++)
                if (req_wstrb[b]) upd[8*b +: 8] = req_wdata[8*b +: 8];
            m_tick = is_wrap;
            if (is_wrap && m_elapsed != 32'hFFFF_FFFF) m_elapsed = m_elapsed + 1;
            if (is_hit) m_shadow = upd;
            if (is_hit && req_wstrb[0] && upd[0]) begin
                m_state = 1;
                m_exit  = upd[31:1];
            end else if (is_wrap && T_OUT != 0 && m_elapsed >= T_OUT) begin
                m_state = 2;
            end
        end else begin
            m_tick = 1'b0;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 1'b0; req_valid = 1'b0; req_ready = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1; req_ready = 1'b1; req_write = 1'b1;
        req_addr = a; req_wdata = d; req_wstrb = s;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({tick, elapsed, eoc, exit_code, pass, timeout} !== 67'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got tick=%0b el=%0d eoc=%0b ec=%0h pass=%0b to=%0b, want all 0",
                     tick, elapsed, eoc, exit_code, pass, timeout);
        end
        rst = 1'b0;
    endtask

    task automatic test_eoc_pass();
        do_clear();
        step();
        vectors++;
        if (eoc !== 1'b0) begin
            miscompares++; $display("FAIL pass_pre_eoc: got %0b want 0", eoc);
        end
        do_write(EOC_A, 32'h0000_0001, 4'hF);
        vectors++;
        if ({eoc, exit_code, pass} !== {1'b1, 31'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL pass_eoc: got eoc=%0b ec=%0h pass=%0b want 1/0/1", eoc, exit_code, pass);
        end
    endtask

    task automatic test_exit_code();
        do_clear();
        do_write(EOC_A | 32'h3, 32'h0000_0055, 4'hF);
        vectors++;
        if ({eoc, exit_code, pass} !== {1'b1, 31'h2A, 1'b0}) begin
            miscompares++;
            $display("FAIL exit_code_55: got eoc=%0b ec=%0h pass=%0b want 1/2a/0", eoc, exit_code, pass);
        end
        do_write(EOC_A, 32'h0000_0001, 4'hF);
        step();
        vectors++;
        if (exit_code !== 31'h2A) begin
            miscompares++; $display("FAIL exit_code_final: got %0h want 2a", exit_code);
        end
    endtask

    task automatic test_bytewise();
        do_clear();
        do_write(EOC_A, 32'h0000_0300, 4'h2);
        vectors++;
        if (eoc !== 1'b0) begin
            miscompares++; $display("FAIL bytewise_first: eoc got %0b want 0", eoc);
        end
        do_write(EOC_A + 32'h4, 32'h0000_0001, 4'h1);
        vectors++;
        if (eoc !== 1'b0) begin
            miscompares++; $display("FAIL bytewise_other_addr: eoc got %0b want 0", eoc);
        end
        do_write(EOC_A, 32'h0000_0001, 4'h1);
        vectors++;
        if ({eoc, exit_code} !== {1'b1, 31'h180}) begin
            miscompares++;
            $display("FAIL bytewise_eoc: got eoc=%0b ec=%0h want 1/180", eoc, exit_code);
        end
    endtask

    task automatic test_timeout();
        logic want_tick;
        do_clear();
        for (int k = 1; k <= 18; k++) begin
            step();
            want_tick = (k == 4) || (k == 8) || (k == 12);
            vectors++;
            if (tick !== want_tick) begin
                miscompares++; $display("FAIL timeout_tick_%0d: got %0b want %0b", k, tick, want_tick);
            end
            vectors++;
            if (timeout !== (k >= 12)) begin
                miscompares++; $display("FAIL timeout_flag_%0d: got %0b want %0b", k, timeout, k >= 12);
            end
        end
        vectors++;
        if ({elapsed, eoc} !== {32'd3, 1'b0}) begin
            miscompares++; $display("FAIL timeout_elapsed: got el=%0d eoc=%0b want 3/0", elapsed, eoc);
        end
        do_write(EOC_A, 32'h1, 4'hF);
        vectors++;
        if (eoc !== 1'b0 || timeout !== 1'b1) begin
            miscompares++; $display("FAIL timeout_sticky: got eoc=%0b to=%0b want 0/1", eoc, timeout);
        end
    endtask

    task automatic test_simultaneous();
        do_clear();
        repeat (11) step();
        do_write(EOC_A, 32'h0000_0009, 4'h1);
        vectors++;
        if ({eoc, timeout, exit_code} !== {1'b1, 1'b0, 31'h4}) begin
            miscompares++;
            $display("FAIL simultaneous: got eoc=%0b to=%0b ec=%0h want 1/0/4", eoc, timeout, exit_code);
        end
        vectors++;
        if (elapsed !== m_elapsed) begin
            miscompares++; $display("FAIL simultaneous_elapsed: got %0d want %0d", elapsed, m_elapsed);
        end
    endtask

    task automatic test_rst_midrun();
        do_clear();
        repeat (6) step();
        do_write(EOC_A, 32'h0000_0011, 4'hF);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({tick, elapsed, eoc, exit_code, pass, timeout} !== 67'd0) begin
            miscompares++;
            $display("FAIL rst_midrun: got tick=%0b el=%0d eoc=%0b ec=%0h to=%0b want all 0",
                     tick, elapsed, eoc, exit_code, timeout);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_clear_after_done();
        do_clear();
        repeat (5) step();
        do_write(EOC_A, 32'h0000_0003, 4'hF);
        do_clear();
        vectors++;
        if ({eoc, elapsed, exit_code, timeout} !== 65'd0) begin
            miscompares++;
            $display("FAIL clear_after_done: got eoc=%0b el=%0d ec=%0h to=%0b want 0", eoc, elapsed, exit_code, timeout);
        end
    endtask

    task automatic test_random();
        do_clear();
        for (int n = 0; n < 600; n++) begin
            clear     = ($urandom_range(0, 11) == 0);
            req_valid = $urandom_range(0, 3) != 0;
            req_ready = $urandom_range(0, 3) != 0;
            req_write = $urandom_range(0, 3) != 0;
            req_addr  = ($urandom_range(0, 2) != 0) ? (EOC_A | 32'($urandom_range(0, 3)))
                                                    : (EOC_A ^ (32'h4 << $urandom_range(0, 20)));
            req_wdata = $urandom() & ~32'(($urandom_range(0, 2) != 0) ? 1 : 0);
            req_wstrb = 4'($urandom());
            step();
            vectors++;
            if ({tick, elapsed, eoc, exit_code, pass, timeout} !==
                {m_tick, m_elapsed, m_state == 1, m_exit, (m_state == 1) && (m_exit == 0), m_state == 2}) begin
                miscompares++;
                $display("FAIL random_%0d: got tick=%0b el=%0d eoc=%0b ec=%0h pass=%0b to=%0b want tick=%0b el=%0d st=%0d ec=%0h",
                         n, tick, elapsed, eoc, exit_code, pass, timeout, m_tick, m_elapsed, m_state, m_exit);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_eoc_pass();
        test_exit_code();
        test_bytewise();
        test_timeout();
        test_simultaneous();
        test_rst_midrun();
        test_clear_after_done();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
